alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the RV32I ALU interface.
- Decodes one instruction per handshake into the 4-bit ALU control code and the two 32-bit operands, then registers them in the ID/EX pipeline register.
- Sits between the register-file read and the combinational ALU.
- Provides valid/ready flow control, synchronous flush, and illegal-instruction flagging.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode-side instruction valid.
- in_ready  out  1  stage can accept an instruction.
- instr  in  32  raw instruction word.
- pc  in  32  instruction address.
- rs1_data  in  32  register file read port 1.
- rs2_data  in  32  register file read port 2.
- flush  in  1  synchronous pipeline flush.
- out_valid  out  1  ID/EX register holds an issued op.
- out_ready  in  1  EX stage consumes the op.
- alu_ctrl  out  4  ALU control code.
- alu_d1  out  32  ALU operand 1.
- alu_d2  out  32  ALU operand 2.
- rd_addr  out  5  destination register.
- reg_write  out  1  writeback enable.
- illegal  out  1  instruction not decodable.

Behaviour:
- ALU control codes: ADD 0000, SUB 0001, SLT 0010, SLTU 0011, SLL 0101, SRL 0110, SRA 0111, AND 1000, OR 1001, XOR 1010. Code 0100 is never emitted.
- Reset (async, rst=1): out_valid=0, alu_ctrl=0000, alu_d1=0, alu_d2=0, rd_addr=0, reg_write=0, illegal=0, all immediately.
- in_ready = !flush && (!out_valid || out_ready). This is combinational.
- Accept condition: in_valid && in_ready. On accept, the decoded fields load at the next rising edge and out_valid=1. Latency is 1 cycle.
- Hold: if out_valid && !out_ready, all outputs stay bit-stable.
- Drain: if out_ready && out_valid and there is no accept, out_valid goes to 0 next cycle. Data outputs keep their last values.
- Back-to-back: consume and accept in the same cycle yields the new op next cycle with no bubble.
- Flush: out_valid goes to 0 next edge, regardless of out_ready. No instruction is accepted during flush.
- Immediates follow RV32I: I, S, B and U formats, sign-extended to 32 bits.
- R-type (0110011), d1=rs1_data, d2=rs2_data:
  - funct7=0000000: funct3 000 ADD, 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL, 110 OR, 111 AND.
  - funct7=0100000: valid only with funct3 000 (SUB) and 101 (SRA).
  - Any other funct7 is illegal.
- I-type ALU (0010011), d1=rs1_data, d2=I-imm, same funct3 map without SUB:
  - Shifts use d2={27'b0, instr[24:20]}.
  - SLLI requires funct7=0000000.
  - funct3 101 selects SRLI with funct7=0000000 and SRAI with funct7=0100000; any other funct7 is illegal.
- LUI (0110111): ADD, d1=0, d2=U-imm.
- AUIPC (0010111): ADD, d1=pc, d2=U-imm.
- LOAD (0000011): ADD, d1=rs1_data, d2=I-imm, reg_write=1.
- STORE (0100011): ADD, d1=rs1_data, d2=S-imm, reg_write=0.
- BRANCH (1100011), d1=rs1_data, d2=rs2_data, reg_write=0:
  - BEQ/BNE use SUB.
  - BLT/BGE use SLT.
  - BLTU/BGEU use SLTU.
  - funct3 010/011 is illegal.
- JAL (1101111): ADD, d1=pc, d2=4, which gives the link address.
- JALR (1100111): same as JAL. Requires funct3=000, otherwise illegal.
- reg_write=1 only for R, I-ALU, LUI, AUIPC, LOAD, JAL and JALR, and only when rd≠0.
- Illegal (any other opcode, including FENCE/SYSTEM, or a bad funct field): the op is still issued with illegal=1, alu_ctrl=0000, d1=0, d2=0, reg_write=0, and rd_addr=instr[11:7].
- Arithmetic: pure field extraction and muxing; no adders in this block.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, out_ready=1 -> next cycle: out_valid=1, alu_ctrl=0000, d1=5, d2=7, rd_addr=3, reg_write=1, illegal=0.
- SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> alu_ctrl=0111, d1=0x80000000, d2=3. Then LUI x1,0x12345 (0x123450B7) -> alu_ctrl=0000, d1=0, d2=0x12345000.
- Backpressure: issue ADD, hold out_ready=0 for 3 cycles while SUB is presented -> in_ready=0 and outputs unchanged for all 3 cycles. Raise out_ready -> SUB (alu_ctrl=0001) appears next cycle, no bubble, no duplicate.
- Flush with out_valid=1, in_valid=1, out_ready=0 -> in_ready=0 that cycle, out_valid=0 next cycle, presented instruction is not issued.
- Illegal 0xFFFFFFFF and R-type funct7=0000001 (MUL) -> illegal=1, reg_write=0, alu_ctrl=0000, d1=d2=0.
- Branch/rd0 and reset:
  - BLTU (funct3 110) -> alu_ctrl=0011, reg_write=0.
  - ADDI x0,x0,1 -> reg_write=0.
  - rst asserted mid-hold -> out_valid=0 before the next clock edge.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I ALU issue stage: decodes one instruction per handshake into
// ALU control and operands, held in the ID/EX register.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] alu_d1,
  output logic [XLEN-1:0] alu_d2,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            illegal
);

  localparam logic [3:0] C_ADD  = 4'b0000;
  localparam logic [3:0] C_SUB  = 4'b0001;
  localparam logic [3:0] C_SLT  = 4'b0010;
  localparam logic [3:0] C_SLTU = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0101;
  localparam logic [3:0] C_SRL  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_AND  = 4'b1000;
  localparam logic [3:0] C_OR   = 4'b1001;
  localparam logic [3:0] C_XOR  = 4'b1010;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;

  localparam logic [6:0] F7_0 = 7'b0000000;
  localparam logic [6:0] F7_A = 7'b0100000;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_u  = {instr[31:12], 12'h000};
  assign shamt  = {27'b0, instr[24:20]};

  // funct3 to ALU code for the shared R/I arithmetic map
  function automatic logic [3:0] f3_code(input logic [2:0] f);
    logic [3:0] c;
    c = C_ADD;
    unique case (f)
      3'b000: c = C_ADD;
      3'b001: c = C_SLL;
      3'b010: c = C_SLT;
      3'b011: c = C_SLTU;
      3'b100: c = C_XOR;
      3'b101: c = C_SRL;
      3'b110: c = C_OR;
      3'b111: c = C_AND;
      default: c = C_ADD;
    endcase
    return c;
  endfunction

  logic        accept;
  logic [3:0]  d_ctrl;
  logic [31:0] d_a;
  logic [31:0] d_b;
  logic        d_wr;
  logic        d_ill;
  logic        d_rw;

  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // decode instruction word into ALU control, operands and flags
  always_comb begin
    d_ctrl = C_ADD;
    d_a    = '0;
    d_b    = '0;
    d_wr   = 1'b0;
    d_ill  = 1'b0;
    d_rw   = 1'b0;
    unique case (opcode)
      OP_R: begin
        d_a  = rs1_data;
        d_b  = rs2_data;
        d_wr = 1'b1;
        if (f7 == F7_0)
          d_ctrl = f3_code(f3);
        else if (f7 == F7_A && f3 == 3'b000)
          d_ctrl = C_SUB;
        else if (f7 == F7_A && f3 == 3'b101)
          d_ctrl = C_SRA;
        else
          d_ill = 1'b1;
      end
      OP_I: begin
        d_a    = rs1_data;
        d_b    = imm_i;
        d_wr   = 1'b1;
        d_ctrl = f3_code(f3);
        if (f3 == 3'b001) begin
          d_b   = shamt;
          d_ill = (f7 != F7_0);
        end else if (f3 == 3'b101) begin
          d_b = shamt;
          if (f7 == F7_A)
            d_ctrl = C_SRA;
          else if (f7 != F7_0)
            d_ill = 1'b1;
        end
      end
      OP_LUI: begin
        d_b  = imm_u;
        d_wr = 1'b1;
      end
      OP_AUI: begin
        d_a  = pc;
        d_b  = imm_u;
        d_wr = 1'b1;
      end
      OP_LD: begin
        d_a  = rs1_data;
        d_b  = imm_i;
        d_wr = 1'b1;
      end
      OP_ST: begin
        d_a = rs1_data;
        d_b = imm_s;
      end
      OP_BR: begin
        d_a = rs1_data;
        d_b = rs2_data;
        unique case (f3[2:1])
          2'b00: d_ctrl = C_SUB;
          2'b10: d_ctrl = C_SLT;
          2'b11: d_ctrl = C_SLTU;
          default: d_ill = 1'b1;
        endcase
      end
      OP_JAL: begin
        d_a  = pc;
        d_b  = 32'd4;
        d_wr = 1'b1;
      end
      OP_JR: begin
        d_a   = pc;
        d_b   = 32'd4;
        d_wr  = 1'b1;
        d_ill = (f3 != 3'b000);
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_ctrl = C_ADD;
      d_a    = '0;
      d_b    = '0;
    end
    d_rw = d_wr && !d_ill && (rd != 5'd0);
  end

  // ID/EX register: load on accept, drop valid on consume or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      alu_ctrl  <= C_ADD;
      alu_d1    <= '0;
      alu_d2    <= '0;
      rd_addr   <= '0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      if (flush)
        out_valid <= 1'b0;
      else if (accept)
        out_valid <= 1'b1;
      else if (out_ready)
        out_valid <= 1'b0;
      if (accept) begin
        alu_ctrl  <= d_ctrl;
        alu_d1    <= d_a;
        alu_d2    <= d_b;
        rd_addr   <= rd;
        reg_write <= d_rw;
        illegal   <= d_ill;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: mnemonic-level reference model checked
// every cycle, plus directed vectors with literal expectations.
module tb_alu_issue_stage;

  logic        clk = 0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_d1;
  logic [31:0] alu_d2;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        illegal;

  int total = 0;
  int bad = 0;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_ctrl(alu_ctrl), .alu_d1(alu_d1), .alu_d2(alu_d2),
    .rd_addr(rd_addr), .reg_write(reg_write),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
  } exp_t;

  function automatic logic [3:0] code_of(input string m);
    case (m)
      "add":  return 4'd0;
      "sub":  return 4'd1;
      "slt":  return 4'd2;
      "sltu": return 4'd3;
      "sll":  return 4'd5;
      "srl":  return 4'd6;
      "sra":  return 4'd7;
      "and":  return 4'd8;
      "or":   return 4'd9;
      "xor":  return 4'd10;
      default: return 4'd4;
    endcase
  endfunction

  // instruction -> mnemonic, operands, then expected outputs
  function automatic exp_t ref_op(input logic [31:0] w,
                                  input logic [31:0] p,
                                  input logic [31:0] r1,
                                  input logic [31:0] r2);
    string names[8] = '{"add", "sll", "slt", "sltu",
                        "xor", "srl", "or", "and"};
    string m = "bad";
    logic [6:0] op = w[6:0];
    int f3 = int'(w[14:12]);
    int f7 = int'(w[31:25]);
    logic [31:0] ii = 32'($signed(w[31:20]));
    logic [31:0] si = 32'($signed({w[31:25], w[11:7]}));
    logic [31:0] ui = {w[31:12], 12'h000};
    logic [31:0] sh = 32'(w[24:20]);
    logic [31:0] a = 0;
    logic [31:0] b = 0;
    bit wr = 0;
    exp_t e;
    if (op == 7'h33) begin
      a = r1; b = r2; wr = 1;
      if (f7 == 0) m = names[f3];
      else if (f7 == 32 && f3 == 0) m = "sub";
      else if (f7 == 32 && f3 == 5) m = "sra";
    end else if (op == 7'h13) begin
      a = r1; b = ii; wr = 1;
      if (f3 == 1 || f3 == 5) b = sh;
      if (f3 == 1) begin
        if (f7 == 0) m = "sll";
      end else if (f3 == 5) begin
        if (f7 == 0) m = "srl";
        else if (f7 == 32) m = "sra";
      end else m = names[f3];
    end else if (op == 7'h37) begin
      m = "add"; b = ui; wr = 1;
    end else if (op == 7'h17) begin
      m = "add"; a = p; b = ui; wr = 1;
    end else if (op == 7'h03) begin
      m = "add"; a = r1; b = ii; wr = 1;
    end else if (op == 7'h23) begin
      m = "add"; a = r1; b = si;
    end else if (op == 7'h63) begin
      a = r1; b = r2;
      if (f3 < 2) m = "sub";
      else if (f3 == 4 || f3 == 5) m = "slt";
      else if (f3 >= 6) m = "sltu";
    end else if (op == 7'h6F || (op == 7'h67 && f3 == 0)) begin
      m = "add"; a = p; b = 4; wr = 1;
    end
    e.rd = w[11:7];
    if (m == "bad") begin
      e.c = 0; e.a = 0; e.b = 0; e.rw = 0; e.ill = 1;
    end else begin
      e.c = code_of(m); e.a = a; e.b = b;
      e.rw = wr && (w[11:7] != 0); e.ill = 0;
    end
    return e;
  endfunction

  logic mv;
  exp_t me;

  // reference pipeline register
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mv <= 0;
      me <= '{c: 0, a: 0, b: 0, rd: 0, rw: 0, ill: 0};
    end else if (flush) begin
      mv <= 0;
    end else if (in_valid && (!mv || out_ready)) begin
      mv <= 1;
      me <= ref_op(instr, pc, rs1_data, rs2_data);
    end else if (out_ready) begin
      mv <= 0;
    end
  end

  // compare DUT against the reference every cycle
  always @(negedge clk) begin
    chk("m_in_ready", 32'(in_ready), 32'(!flush && (!mv || out_ready)));
    chk("m_out_valid", 32'(out_valid), 32'(mv));
    chk("m_ctrl", 32'(alu_ctrl), 32'(me.c));
    chk("m_d1", alu_d1, me.a);
    chk("m_d2", alu_d2, me.b);
    chk("m_rd", 32'(rd_addr), 32'(me.rd));
    chk("m_rw", 32'(reg_write), 32'(me.rw));
    chk("m_ill", 32'(illegal), 32'(me.ill));
  end

  task automatic issue(input logic [31:0] w,
                       input logic [31:0] r1,
                       input logic [31:0] r2);
    in_valid = 1; instr = w; rs1_data = r1; rs2_data = r2;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic lit(input logic v, input logic [3:0] c,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [4:0] rd, input logic rw,
                     input logic il);
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("alu_ctrl", 32'(alu_ctrl), 32'(c));
    chk("alu_d1", alu_d1, a);
    chk("alu_d2", alu_d2, b);
    chk("rd_addr", 32'(rd_addr), 32'(rd));
    chk("reg_write", 32'(reg_write), 32'(rw));
    chk("illegal", 32'(illegal), 32'(il));
  endtask

  logic [31:0] vec[14] = '{
    32'h0020A423, 32'hFFF10093, 32'h008000EF, 32'h00001297,
    32'h000010E7, 32'h000080E7, 32'h0020A063, 32'h02109093,
    32'h0000000F, 32'h00000073, 32'hFFC12083, 32'h0020D1B3,
    32'hFFF13093, 32'h4020D1B3
  };

  initial begin
    rst = 1; in_valid = 0; instr = 0; pc = 32'h100;
    rs1_data = 0; rs2_data = 0; flush = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    lit(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    rst = 0;

    issue(32'h002081B3, 5, 7);
    @(negedge clk);
    lit(1, 4'b0000, 5, 7, 3, 1, 0);
    @(posedge clk); #1;

    issue(32'h40335293, 32'h80000000, 0);
    @(negedge clk);
    lit(1, 4'b0111, 32'h80000000, 3, 5, 1, 0);
    @(posedge clk); #1;
    issue(32'h123450B7, 9, 9);
    @(negedge clk);
    lit(1, 4'b0000, 0, 32'h12345000, 1, 1, 0);
    @(posedge clk); #1;

    issue(32'h002081B3, 5, 7);
    out_ready = 0;
    in_valid = 1; instr = 32'h40208233; rs1_data = 20; rs2_data = 6;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 0);
      lit(1, 4'b0000, 5, 7, 3, 1, 0);
      @(posedge clk); #1;
    end
    out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk);
    lit(1, 4'b0001, 20, 6, 4, 1, 0);
    @(posedge clk); #1;
    @(negedge clk);
    lit(0, 4'b0001, 20, 6, 4, 1, 0);

    @(posedge clk); #1;
    issue(32'h002081B3, 5, 7);
    out_ready = 0; flush = 1;
    in_valid = 1; instr = 32'h0020C1B3;
    @(negedge clk);
    chk("fl_in_ready", 32'(in_ready), 0);
    chk("fl_valid_now", 32'(out_valid), 1);
    @(posedge clk); #1;
    flush = 0; in_valid = 0; out_ready = 1;
    @(negedge clk);
    lit(0, 4'b0000, 5, 7, 3, 1, 0);
    @(posedge clk); #1;

    issue(32'hFFFFFFFF, 3, 4);
    @(negedge clk);
    lit(1, 0, 0, 0, 31, 0, 1);
    @(posedge clk); #1;
    issue(32'h022081B3, 3, 4);
    @(negedge clk);
    lit(1, 0, 0, 0, 3, 0, 1);
    @(posedge clk); #1;

    issue(32'h0020E063, 1, 2);
    @(negedge clk);
    lit(1, 4'b0011, 1, 2, 0, 0, 0);
    @(posedge clk); #1;
    issue(32'h00100013, 0, 0);
    @(negedge clk);
    lit(1, 4'b0000, 0, 1, 0, 0, 0);
    @(posedge clk); #1;
    issue(32'h0020A423, 32'h1000, 2);
    @(negedge clk);
    lit(1, 4'b0000, 32'h1000, 8, 8, 0, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      in_valid = 1; instr = vec[i];
      rs1_data = 32'h11 * (i + 1);
      rs2_data = 32'hF0F0_0000 + i;
      pc = 32'h2000 + 4 * i;
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(posedge clk); #1;

    issue(32'h002081B3, 5, 7);
    out_ready = 0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold_valid", 32'(out_valid), 1);
    #2 rst = 1;
    #1;
    lit(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 0; out_ready = 1;
    repeat (2) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
